// File: rtl/dat_bank_pkg.sv
// Shared op codes, carry-mux selects and shifter state encodings for the
// alpacacorn accumulator datapath (dat_bank / dat_shifter).
package dat_bank_pkg;

  localparam int OP_WIDTH           = 4;
  localparam int CTR_CARRYMUX_WIDTH = 2;

  typedef enum logic [OP_WIDTH-1:0] {
    OP_ADD = 4'd0,
    OP_ADC = 4'd1,
    OP_NOR = 4'd2,
    OP_AND = 4'd3,
    OP_XOR = 4'd4,
    OP_LD  = 4'd5,
    OP_JCC = 4'd6,
    OP_SHL = 4'd7,
    OP_SHR = 4'd8
  } alu_op_e;

  typedef enum logic [CTR_CARRYMUX_WIDTH-1:0] {
    CARRY_OP_GEN  = 2'd0,
    CARRY_OP_CLR  = 2'd1,
    CARRY_OP_SET  = 2'd2,
    CARRY_OP_KEEP = 2'd3
  } carry_op_e;

  typedef enum logic [0:0] {
    SH_IDLE  = 1'b0,
    SH_SHIFT = 1'b1
  } shift_state_e;

  // Only the adders produce a carry that CARRY_OP_GEN may capture.
  function automatic logic op_is_arith(input logic [OP_WIDTH-1:0] op);
    return (op == OP_ADD) || (op == OP_ADC);
  endfunction

endpackage

// File: rtl/dat_bank_if.sv
// Control/data bus between the sequencer (master) and the accumulator bank (slave).
interface dat_bank_if
  import dat_bank_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_COUNT  = 4
);

  localparam int SEL_WIDTH = (ACC_COUNT > 1) ? $clog2(ACC_COUNT) : 1;

  logic [DATA_WIDTH-1:0]         data_i;
  logic [OP_WIDTH-1:0]           ctr_aluop_i;
  logic [CTR_CARRYMUX_WIDTH-1:0] ctr_carrymux_i;
  logic [SEL_WIDTH-1:0]          ctr_acc_sel_i;
  logic                          ctr_a_reg_en_i;
  logic [DATA_WIDTH-1:0]         data_o;
  logic                          carry_o;
  logic                          zero_o;
  logic                          busy_o;

  modport master (
    output data_i, ctr_aluop_i, ctr_carrymux_i, ctr_acc_sel_i, ctr_a_reg_en_i,
    input  data_o, carry_o, zero_o, busy_o
  );

  modport slave (
    input  data_i, ctr_aluop_i, ctr_carrymux_i, ctr_acc_sel_i, ctr_a_reg_en_i,
    output data_o, carry_o, zero_o, busy_o
  );

endinterface

// File: rtl/dat_shifter.sv
// Serial one-bit-per-cycle shifter; raises a one-cycle done strobe together
// with the final result and the last bit shifted out.
module dat_shifter
  import dat_bank_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   start_i,
  input  logic                   dir_right_i,
  input  logic [DATA_WIDTH-1:0]  operand_i,
  input  logic [SHAMT_WIDTH-1:0] amount_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [DATA_WIDTH-1:0]  result_o,
  output logic                   carry_o
);

  shift_state_e           state_q;
  logic [DATA_WIDTH-1:0]  sh_q;
  logic [SHAMT_WIDTH-1:0] cnt_q;
  logic                   dir_q;
  logic [DATA_WIDTH-1:0]  shifted;
  logic                   bit_out;

  always_comb begin
    if (dir_q) begin
      shifted = {1'b0, sh_q[DATA_WIDTH-1:1]};
      bit_out = sh_q[0];
    end else begin
      shifted = {sh_q[DATA_WIDTH-2:0], 1'b0};
      bit_out = sh_q[DATA_WIDTH-1];
    end
  end

  // The final shift and the writeback share one edge, so done is combinational.
  assign done_o   = (state_q == SH_SHIFT) && (cnt_q == SHAMT_WIDTH'(1));
  assign result_o = shifted;
  assign carry_o  = bit_out;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= SH_IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      busy_o  <= 1'b0;
    end else begin
      case (state_q)
        SH_IDLE: begin
          if (start_i && (amount_i != '0)) begin
            state_q <= SH_SHIFT;
            sh_q    <= operand_i;
            cnt_q   <= amount_i;
            dir_q   <= dir_right_i;
            busy_o  <= 1'b1;
          end
        end
        SH_SHIFT: begin
          sh_q  <= shifted;
          cnt_q <= cnt_q - SHAMT_WIDTH'(1);
          if (cnt_q == SHAMT_WIDTH'(1)) begin
            state_q <= SH_IDLE;
            busy_o  <= 1'b0;
          end
        end
        default: begin
          state_q <= SH_IDLE;
          busy_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/dat_bank.sv
// Accumulator register file, single-cycle ALU and carry flag; multi-cycle
// shifts are delegated to dat_shifter and locked out via busy_o.
module dat_bank
  import dat_bank_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_COUNT  = 4
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  dat_bank_if.slave bus
);

  localparam int SEL_WIDTH   = (ACC_COUNT > 1) ? $clog2(ACC_COUNT) : 1;
  localparam int SHAMT_WIDTH = $clog2(DATA_WIDTH);

  logic [DATA_WIDTH-1:0]         acc [ACC_COUNT];
  logic                          carry_q;
  logic [SEL_WIDTH-1:0]          tgt_q;
  logic [CTR_CARRYMUX_WIDTH-1:0] cmux_q;

  logic [DATA_WIDTH-1:0] op_a;
  logic [DATA_WIDTH-1:0] alu_res;
  logic [DATA_WIDTH:0]   sum;
  logic                  alu_wr;
  logic                  idle;
  logic                  wr_en;
  logic                  shift_req;
  logic                  sh_busy;
  logic                  sh_done;
  logic                  sh_cout;
  logic [DATA_WIDTH-1:0] sh_result;

  assign idle      = !sh_busy;
  assign op_a      = acc[bus.ctr_acc_sel_i];
  assign wr_en     = idle && bus.ctr_a_reg_en_i && alu_wr;
  assign shift_req = idle && bus.ctr_a_reg_en_i &&
                     ((bus.ctr_aluop_i == OP_SHL) || (bus.ctr_aluop_i == OP_SHR));

  always_comb begin
    alu_res = '0;
    alu_wr  = 1'b0;
    sum     = {1'b0, op_a} + {1'b0, bus.data_i} +
              {{DATA_WIDTH{1'b0}}, (bus.ctr_aluop_i == OP_ADC) & carry_q};
    case (bus.ctr_aluop_i)
      OP_ADD, OP_ADC: begin alu_res = sum[DATA_WIDTH-1:0];     alu_wr = 1'b1; end
      OP_NOR:         begin alu_res = ~(op_a | bus.data_i);    alu_wr = 1'b1; end
      OP_AND:         begin alu_res = op_a & bus.data_i;       alu_wr = 1'b1; end
      OP_XOR:         begin alu_res = op_a ^ bus.data_i;       alu_wr = 1'b1; end
      OP_LD:          begin alu_res = bus.data_i;              alu_wr = 1'b1; end
      default:        begin alu_res = '0;                      alu_wr = 1'b0; end
    endcase
  end

  dat_shifter #(
    .DATA_WIDTH (DATA_WIDTH),
    .SHAMT_WIDTH(SHAMT_WIDTH)
  ) u_shifter (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .start_i    (shift_req),
    .dir_right_i(bus.ctr_aluop_i == OP_SHR),
    .operand_i  (op_a),
    .amount_i   (bus.data_i[SHAMT_WIDTH-1:0]),
    .busy_o     (sh_busy),
    .done_o     (sh_done),
    .result_o   (sh_result),
    .carry_o    (sh_cout)
  );

  // Shift writeback and ALU writes are mutually exclusive (busy vs. idle).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < ACC_COUNT; i++) begin
        acc[i] <= '0;
      end
      tgt_q  <= '0;
      cmux_q <= '0;
    end else begin
      if (sh_done) begin
        acc[tgt_q] <= sh_result;
      end else if (wr_en) begin
        acc[bus.ctr_acc_sel_i] <= alu_res;
      end
      if (shift_req) begin
        tgt_q  <= bus.ctr_acc_sel_i;
        cmux_q <= bus.ctr_carrymux_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      carry_q <= 1'b0;
    end else if (sh_done) begin
      case (cmux_q)
        CARRY_OP_GEN: carry_q <= sh_cout;
        CARRY_OP_CLR: carry_q <= 1'b0;
        CARRY_OP_SET: carry_q <= 1'b1;
        default:      carry_q <= carry_q;
      endcase
    end else if (idle) begin
      case (bus.ctr_carrymux_i)
        CARRY_OP_GEN: begin
          if (bus.ctr_a_reg_en_i && op_is_arith(bus.ctr_aluop_i)) begin
            carry_q <= sum[DATA_WIDTH];
          end
        end
        CARRY_OP_CLR: carry_q <= 1'b0;
        CARRY_OP_SET: carry_q <= 1'b1;
        default:      carry_q <= carry_q;
      endcase
    end
  end

  assign bus.data_o  = op_a;
  assign bus.zero_o  = (op_a == '0);
  assign bus.carry_o = carry_q;
  assign bus.busy_o  = sh_busy;

endmodule

// File: tb/tb_dat_bank.sv
// Directed bench for dat_bank: vector table for single-cycle ops plus
// hand-written sequences for wrap-around, serial shifts, lockout and reset.
module tb_dat_bank;
  import dat_bank_pkg::*;

  localparam int DW = 8;
  localparam int AC = 4;

  typedef struct {
    logic [1:0] sel;
    logic [3:0] op;
    logic [1:0] cmux;
    logic       en;
    logic [7:0] data;
    logic [7:0] exp_data;
    logic       exp_carry;
    logic       exp_zero;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs[16];

  always #5 clk = ~clk;

  dat_bank_if #(.DATA_WIDTH(DW), .ACC_COUNT(AC)) bus ();

  dat_bank #(.DATA_WIDTH(DW), .ACC_COUNT(AC)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  task automatic applyStimulus(input logic [1:0] sel, input logic [3:0] op,
                               input logic [1:0] cmux, input logic en,
                               input logic [7:0] data);
    bus.ctr_acc_sel_i  = sel;
    bus.ctr_aluop_i    = op;
    bus.ctr_carrymux_i = cmux;
    bus.ctr_a_reg_en_i = en;
    bus.data_i         = data;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] got,
                             input logic [31:0] expected);
    checks++;
    if (got !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkAcc(input string name, input logic [1:0] sel,
                          input logic [7:0] expected);
    bus.ctr_acc_sel_i = sel;
    #1;
    checkOutput(name, bus.data_o, expected);
  endtask

  task automatic doReset();
    applyStimulus(2'd0, OP_JCC, CARRY_OP_KEEP, 1'b0, 8'h00);
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Starts a shift, idles with en=0, and measures how long busy_o stays high.
  task automatic runShift(input string name, input logic [1:0] sel,
                          input logic [3:0] op, input int amount,
                          input logic [7:0] start_val, input logic [7:0] exp_val,
                          input logic exp_carry);
    int busy_cycles = 0;
    bit held = 1'b1;
    applyStimulus(sel, op, CARRY_OP_GEN, 1'b1, 8'(amount));
    tick();
    applyStimulus(sel, OP_LD, CARRY_OP_KEEP, 1'b0, 8'h5A);
    while (bus.busy_o === 1'b1 && busy_cycles < 40) begin
      busy_cycles++;
      if (bus.data_o !== start_val) held = 1'b0;
      tick();
    end
    checkOutput({name, " busy cycles"}, busy_cycles, amount);
    checkOutput({name, " pre-value held"}, held, 1'b1);
    checkOutput({name, " result"}, bus.data_o, exp_val);
    checkOutput({name, " carry"}, bus.carry_o, exp_carry);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int busy_cycles;
    bit lock_ok;

    vecs[0]  = '{2'd2, OP_LD,  CARRY_OP_GEN,  1'b1, 8'h10, 8'h10, 1'b0, 1'b0};
    vecs[1]  = '{2'd2, OP_ADD, CARRY_OP_SET,  1'b0, 8'h33, 8'h10, 1'b1, 1'b0};
    vecs[2]  = '{2'd2, OP_ADC, CARRY_OP_GEN,  1'b1, 8'h05, 8'h16, 1'b0, 1'b0};
    vecs[3]  = '{2'd2, OP_ADD, CARRY_OP_SET,  1'b0, 8'h01, 8'h16, 1'b1, 1'b0};
    vecs[4]  = '{2'd2, OP_ADD, CARRY_OP_CLR,  1'b0, 8'h01, 8'h16, 1'b0, 1'b0};
    vecs[5]  = '{2'd1, OP_NOR, CARRY_OP_GEN,  1'b1, 8'h00, 8'hFF, 1'b0, 1'b0};
    vecs[6]  = '{2'd1, OP_NOR, CARRY_OP_GEN,  1'b1, 8'hFF, 8'h00, 1'b0, 1'b1};
    vecs[7]  = '{2'd1, OP_LD,  CARRY_OP_GEN,  1'b1, 8'hF0, 8'hF0, 1'b0, 1'b0};
    vecs[8]  = '{2'd1, OP_AND, CARRY_OP_GEN,  1'b1, 8'h3C, 8'h30, 1'b0, 1'b0};
    vecs[9]  = '{2'd1, OP_XOR, CARRY_OP_GEN,  1'b1, 8'hFF, 8'hCF, 1'b0, 1'b0};
    vecs[10] = '{2'd1, OP_ADD, CARRY_OP_GEN,  1'b1, 8'h40, 8'h0F, 1'b1, 1'b0};
    vecs[11] = '{2'd1, OP_JCC, CARRY_OP_KEEP, 1'b1, 8'h55, 8'h0F, 1'b1, 1'b0};
    vecs[12] = '{2'd1, 4'hF,   CARRY_OP_GEN,  1'b1, 8'h99, 8'h0F, 1'b1, 1'b0};
    vecs[13] = '{2'd1, OP_AND, CARRY_OP_GEN,  1'b1, 8'h00, 8'h00, 1'b1, 1'b1};
    vecs[14] = '{2'd1, OP_ADD, CARRY_OP_GEN,  1'b1, 8'h00, 8'h00, 1'b0, 1'b1};
    vecs[15] = '{2'd0, OP_LD,  CARRY_OP_KEEP, 1'b1, 8'h77, 8'h77, 1'b0, 1'b0};

    applyStimulus(2'd0, OP_JCC, CARRY_OP_KEEP, 1'b0, 8'h00);
    #2;
    doReset();
    for (int i = 0; i < AC; i++) checkAcc($sformatf("reset acc%0d", i), 2'(i), 8'h00);
    checkOutput("reset carry", bus.carry_o, 1'b0);
    checkOutput("reset busy", bus.busy_o, 1'b0);
    checkOutput("reset zero", bus.zero_o, 1'b1);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].sel, vecs[i].op, vecs[i].cmux, vecs[i].en, vecs[i].data);
      tick();
      checkOutput($sformatf("vec%0d data", i), bus.data_o, vecs[i].exp_data);
      checkOutput($sformatf("vec%0d carry", i), bus.carry_o, vecs[i].exp_carry);
      checkOutput($sformatf("vec%0d zero", i), bus.zero_o, vecs[i].exp_zero);
    end
    applyStimulus(2'd0, OP_JCC, CARRY_OP_KEEP, 1'b0, 8'h00);
    checkAcc("table acc1", 2'd1, 8'h00);
    checkAcc("table acc2", 2'd2, 8'h16);
    checkAcc("table acc3", 2'd3, 8'h00);

    doReset();
    applyStimulus(2'd1, OP_ADD, CARRY_OP_GEN, 1'b1, 8'h01);
    repeat (255) tick();
    checkOutput("wrap 255 data", bus.data_o, 8'hFF);
    checkOutput("wrap 255 carry", bus.carry_o, 1'b0);
    tick();
    applyStimulus(2'd1, OP_ADD, CARRY_OP_KEEP, 1'b0, 8'h01);
    checkOutput("wrap 256 data", bus.data_o, 8'h00);
    checkOutput("wrap 256 carry", bus.carry_o, 1'b1);
    checkOutput("wrap 256 zero", bus.zero_o, 1'b1);
    checkAcc("wrap acc0", 2'd0, 8'h00);
    checkAcc("wrap acc2", 2'd2, 8'h00);
    checkAcc("wrap acc3", 2'd3, 8'h00);

    doReset();
    applyStimulus(2'd3, OP_LD, CARRY_OP_KEEP, 1'b1, 8'h81);
    tick();
    applyStimulus(2'd3, OP_ADD, CARRY_OP_SET, 1'b0, 8'h00);
    tick();
    runShift("shl3", 2'd3, OP_SHL, 3, 8'h81, 8'h08, 1'b0);
    applyStimulus(2'd3, OP_LD, CARRY_OP_KEEP, 1'b1, 8'h81);
    tick();
    runShift("shr1", 2'd3, OP_SHR, 1, 8'h81, 8'h40, 1'b1);
    runShift("shl0", 2'd3, OP_SHL, 0, 8'h40, 8'h40, 1'b1);

    // Lockout: control traffic during a 5-cycle shift must be ignored.
    applyStimulus(2'd0, OP_LD, CARRY_OP_KEEP, 1'b1, 8'hE3);
    tick();
    applyStimulus(2'd0, OP_ADD, CARRY_OP_CLR, 1'b0, 8'h00);
    tick();
    applyStimulus(2'd0, OP_SHR, CARRY_OP_GEN, 1'b1, 8'h05);
    tick();
    applyStimulus(2'd2, OP_LD, CARRY_OP_SET, 1'b1, 8'hAA);
    busy_cycles = 0;
    lock_ok = 1'b1;
    while (bus.busy_o === 1'b1 && busy_cycles < 40) begin
      busy_cycles++;
      if (bus.carry_o !== 1'b0 || bus.data_o !== 8'h00) lock_ok = 1'b0;
      tick();
    end
    applyStimulus(2'd0, OP_JCC, CARRY_OP_KEEP, 1'b0, 8'h00);
    checkOutput("lock busy cycles", busy_cycles, 5);
    checkOutput("lock inputs ignored", lock_ok, 1'b1);
    checkOutput("lock carry", bus.carry_o, 1'b0);
    checkAcc("lock acc0", 2'd0, 8'h07);
    checkAcc("lock acc2", 2'd2, 8'h00);

    for (int i = 0; i < 10; i++) begin
      applyStimulus(2'(i), 4'(i % 9), CARRY_OP_KEEP, 1'b0, 8'(i * 37));
      tick();
    end
    checkAcc("hold acc0", 2'd0, 8'h07);
    checkAcc("hold acc1", 2'd1, 8'h00);
    checkAcc("hold acc2", 2'd2, 8'h00);
    checkAcc("hold acc3", 2'd3, 8'h40);

    applyStimulus(2'd0, OP_ADD, CARRY_OP_SET, 1'b0, 8'h00);
    tick();
    applyStimulus(2'd0, OP_LD, CARRY_OP_KEEP, 1'b1, 8'h01);
    tick();
    applyStimulus(2'd0, OP_SHL, CARRY_OP_GEN, 1'b1, 8'h07);
    tick();
    applyStimulus(2'd0, OP_JCC, CARRY_OP_KEEP, 1'b0, 8'h00);
    tick();
    tick();
    checkOutput("mid-shift busy", bus.busy_o, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async reset busy", bus.busy_o, 1'b0);
    checkOutput("async reset acc0", bus.data_o, 8'h00);
    checkOutput("async reset carry", bus.carry_o, 1'b0);
    checkAcc("async reset acc3", 2'd3, 8'h00);
    bus.ctr_acc_sel_i = 2'd0;
    tick();
    rst_n = 1'b1;
    repeat (10) tick();
    checkOutput("post reset acc0", bus.data_o, 8'h00);
    checkOutput("post reset busy", bus.busy_o, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
